tbus_mem_responder: RTL and testbench
=====================================

# tbus_mem_responder

Responder (slave) end of the tbus request protocol: accepts one read or write transaction at a time from a tbus initiator (dcache arbiter side) and services it against an internal word-addressed memory array. It returns a one-cycle completion pulse with read data after a fixed, parameterised latency. It serves as the dcache/backing-store model behind the arbiter in backend simulation and as the template for real tbus targets.

## Interface
Parameters:
- DEPTH_LOG2, 10: log2 of memory depth in 64-bit words.
- LATENCY, 2: cycles from accept to `tbus_operation_done`; legal range 1..15.

Ports:
- clock  in  1  clock; all state updates on rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- tbus_index_valid  in  1  request strobe; initiator drives a one-cycle pulse.
- tbus_index_ready  out  1  responder idle and able to accept.
- tbus_index  in  64  byte address; word select = index[DEPTH_LOG2+2:3], index[2:0] ignored.
- tbus_write_data  in  64  store data.
- tbus_write_mask  in  64  bit-granular write enable; 1 = bit written.
- tbus_operation_type  in  2  2'b00 READ, 2'b01 WRITE; any other value treated as READ.
- tbus_read_data  out  64  read result; valid in the done cycle and held until next done.
- tbus_operation_done  out  1  one-cycle completion pulse.
- tbus_error  out  1  out-of-range flag, valid with done (see Configuration).

## Operation
- FSM states: IDLE, BUSY.
- IDLE: ready=1. If valid=1, accept at that edge. Latch type and word index. Load counter with LATENCY-1. Go to BUSY.
- Write at accept edge: mem[w] <= (mem[w] & ~mask) | (wdata & mask). The array is updated at the accept edge, not at done.
- Read at accept edge: mem[w] is sampled into a pending-data register. The returned value is the array contents at accept time.
- BUSY: ready=0. Counter decrements each cycle. When counter==0, done=1 for that cycle and tbus_read_data <= pending data (reads only). Return to IDLE next cycle.
- Writes also pulse done. tbus_read_data keeps its previous value on write completion.
- valid while BUSY: ignored. No queueing, no error. The initiator must reissue.
- valid and done never overlap because ready=0 during the done cycle.
- Back-to-back transactions to the same word: the read after a write returns the written data.
- Memory array is not reset and is not initialised (X in simulation until written).

## Timing
- Reset values: state=IDLE, tbus_index_ready=1, tbus_operation_done=0, tbus_read_data=0, tbus_error=0, counter=0.
- Cycle 0: valid=1 and ready=1, request accepted at the end of cycle 0.
- Cycles 1..LATENCY: ready=0.
- Cycle LATENCY: done=1, read_data valid in the same cycle.
- Cycle LATENCY+1: ready=1; the earliest next accept is in this cycle.
- Throughput: one transaction per LATENCY+1 cycles.
- ready is a registered output; no combinational path from inputs to ready.
- done and read_data are registered outputs, held stable for the whole done cycle.
- Reset asserted mid-transaction: return immediately to IDLE, drop the pending read, no done pulse. A write already committed at the accept edge stays in memory.

## Configuration
- TBUS_RESP_BOUNDS_CHK_EN defined: if index[63:DEPTH_LOG2+3] != 0, the request is out of range.
  - Out-of-range write: memory not modified.
  - Out-of-range read: returns 64'h0.
  - tbus_error=1 in the done cycle; 0 otherwise. Timing is unchanged.
- TBUS_RESP_BOUNDS_CHK_EN undefined: upper address bits are ignored, so addresses alias modulo depth, and tbus_error is tied 0.

## Test plan
- Reset then idle: after reset_n deasserts, ready=1, done=0, read_data=0, error=0 for 10 cycles with no valid.
- Write then read: write index 0x40, data 0xDEADBEEF_CAFEF00D, mask all-ones; then read 0x40 in the cycle after ready returns. Required: done in cycle LATENCY after each accept; read_data=0xDEADBEEF_CAFEF00D.
- Masked write: preload 0x40 with all-ones; write data 0, mask 0x0000_0000_FFFF_0000; read back. Required: 0xFFFF_FFFF_0000_FFFF.
- Busy drop and latency: LATENCY=3; a second valid 1 cycle after accept is ignored. Required: exactly one done, 3 cycles after accept; ready low for 3 cycles.
- Reset mid-read: assert reset_n=0 one cycle after accepting a read. Required: no done pulse; ready=1 after release; a subsequent read returns the stored data.
- Bounds: with TBUS_RESP_BOUNDS_CHK_EN, read index 1<<(DEPTH_LOG2+3). Required: data 0, error=1 with done. Without the macro: returns the word-0 contents, error=0.

Source files
------------

// File: rtl/tbus_mem_responder.sv
// rtl/tbus_mem_responder.sv - tbus responder servicing one read/write at a time from a word-addressed memory; optional macro TBUS_RESP_BOUNDS_CHK_EN
module tbus_mem_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        tbus_index_valid,
    output logic        tbus_index_ready,
    input  logic [63:0] tbus_index,
    input  logic [63:0] tbus_write_data,
    input  logic [63:0] tbus_write_mask,
    input  logic [1:0]  tbus_operation_type,
    output logic [63:0] tbus_read_data,
    output logic        tbus_operation_done,
    output logic        tbus_error
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                r_state;
    logic [3:0]            r_count;
    logic                  r_ready;
    logic                  r_done;
    logic                  r_error;
    logic                  r_is_read;
    logic                  r_oor;
    logic [63:0]           r_pend;
    logic [63:0]           r_read_data;
    logic [63:0]           r_mem [DEPTH];

    logic [DEPTH_LOG2-1:0] w_word;
    logic                  w_accept;
    logic                  w_is_write;
    logic                  w_oor;
    logic                  w_mem_we;
    logic [63:0]           w_mem_rdata;
    logic [63:0]           w_read_value;
    logic                  w_unused;

    assign w_word     = tbus_index[DEPTH_LOG2+2:3];
    assign w_is_write = (tbus_operation_type == 2'b01);
    // Reset gates the accept so a strobe held during reset cannot touch memory.
    assign w_accept   = reset_n & tbus_index_valid & r_ready & (r_state == ST_IDLE);

`ifdef TBUS_RESP_BOUNDS_CHK_EN
    assign w_oor = |tbus_index[63:DEPTH_LOG2+3];
`else
    assign w_oor = 1'b0;
`endif

    // Byte-offset bits, and upper bits when aliasing, carry no information here.
    assign w_unused = ^{tbus_index[63:DEPTH_LOG2+3], tbus_index[2:0]};

    assign w_mem_we     = w_accept & w_is_write & ~w_oor;
    assign w_mem_rdata  = r_mem[w_word];
    assign w_read_value = w_oor ? 64'h0 : w_mem_rdata;

    // Memory array: bit-masked write committed at the accept edge, never reset.
    always_ff @(posedge clock) begin
        if (w_mem_we) begin
            r_mem[w_word] <= (r_mem[w_word] & ~tbus_write_mask)
                           | (tbus_write_data & tbus_write_mask);
        end
    end

    // Transaction FSM: accept in IDLE, count down in BUSY, registered done/data/error.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_count     <= 4'd0;
            r_ready     <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_is_read   <= 1'b0;
            r_oor       <= 1'b0;
            r_pend      <= 64'h0;
            r_read_data <= 64'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done  <= 1'b0;
                    r_error <= 1'b0;
                    if (w_accept) begin
                        r_state   <= ST_BUSY;
                        r_ready   <= 1'b0;
                        r_count   <= 4'(LATENCY - 1);
                        r_is_read <= ~w_is_write;
                        r_oor     <= w_oor;
                        r_pend    <= w_read_value;
                        // With single-cycle latency the done cycle follows the accept directly.
                        if (LATENCY == 1) begin
                            r_done  <= 1'b1;
                            r_error <= w_oor;
                            if (!w_is_write) begin
                                r_read_data <= w_read_value;
                            end
                        end
                    end
                end
                ST_BUSY: begin
                    if (r_count == 4'd0) begin
                        // This is the done cycle; ready returns next cycle.
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                        r_done  <= 1'b0;
                        r_error <= 1'b0;
                    end else begin
                        r_count <= r_count - 4'd1;
                        if (r_count == 4'd1) begin
                            r_done  <= 1'b1;
                            r_error <= r_oor;
                            if (r_is_read) begin
                                r_read_data <= r_pend;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                    r_done  <= 1'b0;
                    r_error <= 1'b0;
                end
            endcase
        end
    end

    assign tbus_index_ready    = r_ready;
    assign tbus_operation_done = r_done;
    assign tbus_read_data      = r_read_data;
    assign tbus_error          = r_error;

endmodule

// File: tb/tb_tbus_mem_responder.sv
// tb/tb_tbus_mem_responder.sv - self-checking bench for tbus_mem_responder
module tb_tbus_mem_responder;

    localparam int DL2   = 4;
    localparam int LAT   = 3;
    localparam int DEPTH = 1 << DL2;

`ifdef TBUS_RESP_BOUNDS_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        tbus_index_valid = 1'b0;
    logic        tbus_index_ready;
    logic [63:0] tbus_index = 64'h0;
    logic [63:0] tbus_write_data = 64'h0;
    logic [63:0] tbus_write_mask = 64'h0;
    logic [1:0]  tbus_operation_type = 2'b00;
    logic [63:0] tbus_read_data;
    logic        tbus_operation_done;
    logic        tbus_error;

    always #5 clock = ~clock;

    tbus_mem_responder #(.DEPTH_LOG2(DL2), .LATENCY(LAT)) dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .tbus_index_valid    (tbus_index_valid),
        .tbus_index_ready    (tbus_index_ready),
        .tbus_index          (tbus_index),
        .tbus_write_data     (tbus_write_data),
        .tbus_write_mask     (tbus_write_mask),
        .tbus_operation_type (tbus_operation_type),
        .tbus_read_data      (tbus_read_data),
        .tbus_operation_done (tbus_operation_done),
        .tbus_error          (tbus_error)
    );

    int          total = 0;
    int          bad = 0;
    logic [63:0] model [DEPTH];
    logic [63:0] last_rd = 64'h0;

    typedef struct {
        logic [1:0]  op;
        logic [63:0] idx;
        logic [63:0] wd;
        logic [63:0] wm;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic bit is_oor(input logic [63:0] idx);
        return CHK && ((idx >> (DL2 + 3)) != 64'h0);
    endfunction

    // Applies one transaction to the reference memory and returns the expected read_data.
    function automatic logic [63:0] model_apply(input logic [1:0] op, input logic [63:0] idx,
                                                input logic [63:0] wd, input logic [63:0] wm);
        int w;
        w = int'(idx[DL2+2:3]);
        if (op == 2'b01) begin
            if (!is_oor(idx)) model[w] = (model[w] & ~wm) | (wd & wm);
            return last_rd;
        end
        return is_oor(idx) ? 64'h0 : model[w];
    endfunction

    task automatic do_txn(input string name, input logic [1:0] op, input logic [63:0] idx,
                          input logic [63:0] wd, input logic [63:0] wm,
                          input logic [63:0] exp_rd, input logic exp_err);
        int n;
        int ready_hi;
        n = 0;
        while (!tbus_index_ready && n < 20) begin
            step();
            n++;
        end
        check({name, " ready_before"}, 64'(tbus_index_ready), 64'd1);
        tbus_index_valid    = 1'b1;
        tbus_operation_type = op;
        tbus_index          = idx;
        tbus_write_data     = wd;
        tbus_write_mask     = wm;
        step();
        tbus_index_valid = 1'b0;
        n = 1;
        ready_hi = 0;
        while (!tbus_operation_done && n < 20) begin
            if (tbus_index_ready) ready_hi++;
            step();
            n++;
        end
        if (tbus_index_ready) ready_hi++;
        check({name, " latency"}, 64'(n), 64'(LAT));
        check({name, " ready_low"}, 64'(ready_hi), 64'd0);
        check({name, " rdata"}, tbus_read_data, exp_rd);
        check({name, " error"}, 64'(tbus_error), 64'(exp_err));
        step();
        check({name, " done_pulse"}, 64'(tbus_operation_done), 64'd0);
        check({name, " ready_back"}, 64'(tbus_index_ready), 64'd1);
        check({name, " error_clr"}, 64'(tbus_error), 64'd0);
        check({name, " rdata_hold"}, tbus_read_data, exp_rd);
    endtask

    task automatic run(input string name, input logic [1:0] op, input logic [63:0] idx,
                       input logic [63:0] wd, input logic [63:0] wm);
        logic [63:0] e;
        e = model_apply(op, idx, wd, wm);
        do_txn(name, op, idx, wd, wm, e, is_oor(idx));
        last_rd = e;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;
        int done_cyc;
        int ready_low;
        logic [63:0] idx;
        logic [63:0] msk;
        logic [1:0]  op;
        logic [63:0] e;

        vecs[0] = '{2'b01, 64'h40, 64'hDEADBEEF_CAFEF00D, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
        vecs[1] = '{2'b00, 64'h40, 64'h0, 64'h0, 64'hDEADBEEF_CAFEF00D};
        vecs[2] = '{2'b01, 64'h40, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
        vecs[3] = '{2'b01, 64'h40, 64'h0, 64'h0000_0000_FFFF_0000, 64'h0};
        vecs[4] = '{2'b00, 64'h40, 64'h0, 64'h0, 64'hFFFF_FFFF_0000_FFFF};
        vecs[5] = '{2'b01, 64'h50, 64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
        vecs[6] = '{2'b01, 64'h50, 64'hFFFF_FFFF_0000_0000, 64'hFF00_FF00_FF00_FF00, 64'h0};
        vecs[7] = '{2'b10, 64'h50, 64'h0, 64'h0, 64'hFF23_FF67_00AB_00EF};
        vecs[8] = '{2'b01, 64'h50, 64'h0, 64'h0, 64'h0};
        vecs[9] = '{2'b11, 64'h57, 64'h0, 64'h0, 64'hFF23_FF67_00AB_00EF};

        repeat (3) step();
        reset_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            check("reset_ready", 64'(tbus_index_ready), 64'd1);
            check("reset_done", 64'(tbus_operation_done), 64'd0);
            check("reset_rdata", tbus_read_data, 64'h0);
            check("reset_error", 64'(tbus_error), 64'd0);
        end

        for (int w = 0; w < DEPTH; w++) begin
            run("preload", 2'b01, 64'(w) << 3, {$urandom, $urandom}, 64'hFFFF_FFFF_FFFF_FFFF);
        end

        for (int i = 0; i < 10; i++) begin
            e = (vecs[i].op == 2'b01) ? last_rd : vecs[i].exp;
            do_txn($sformatf("vec%0d", i), vecs[i].op, vecs[i].idx, vecs[i].wd, vecs[i].wm, e, 1'b0);
            last_rd = model_apply(vecs[i].op, vecs[i].idx, vecs[i].wd, vecs[i].wm);
        end

        // A strobe one cycle after accept must be dropped.
        tbus_index_valid = 1'b1; tbus_operation_type = 2'b01; tbus_index = 64'h38;
        tbus_write_data = 64'h1111_2222_3333_4444; tbus_write_mask = '1;
        step();
        e = model_apply(2'b01, 64'h38, 64'h1111_2222_3333_4444, '1);
        tbus_write_data = 64'h9999_8888_7777_6666;
        dones = 0; done_cyc = 0; ready_low = 0;
        for (int c = 1; c <= 10; c++) begin
            if (!tbus_index_ready) ready_low++;
            if (tbus_operation_done) begin dones++; done_cyc = c; end
            step();
            tbus_index_valid = 1'b0;
        end
        check("drop_done_count", 64'(dones), 64'd1);
        check("drop_done_cycle", 64'(done_cyc), 64'(LAT));
        check("drop_ready_low", 64'(ready_low), 64'(LAT));
        run("drop_readback", 2'b00, 64'h38, 64'h0, 64'h0);

        // Reset one cycle after accepting a read.
        tbus_index_valid = 1'b1; tbus_operation_type = 2'b00; tbus_index = 64'h28;
        step();
        tbus_index_valid = 1'b0;
        step();
        reset_n = 1'b0;
        #1;
        check("rst_mid_ready", 64'(tbus_index_ready), 64'd1);
        check("rst_mid_done", 64'(tbus_operation_done), 64'd0);
        step(); step();
        reset_n = 1'b1;
        last_rd = 64'h0;
        dones = 0;
        for (int c = 0; c < LAT + 3; c++) begin
            if (tbus_operation_done) dones++;
            step();
        end
        check("rst_mid_no_done", 64'(dones), 64'd0);
        check("rst_mid_rdata", tbus_read_data, 64'h0);
        run("rst_mid_read", 2'b00, 64'h28, 64'h0, 64'h0);

        // A write committed at accept survives a reset before done.
        tbus_index_valid = 1'b1; tbus_operation_type = 2'b01; tbus_index = 64'h30;
        tbus_write_data = 64'hA5A5_5A5A_0F0F_F0F0; tbus_write_mask = 64'h0000_FFFF_FFFF_0000;
        step();
        tbus_index_valid = 1'b0;
        e = model_apply(2'b01, 64'h30, 64'hA5A5_5A5A_0F0F_F0F0, 64'h0000_FFFF_FFFF_0000);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        last_rd = 64'h0;
        step();
        run("rst_write_kept", 2'b00, 64'h30, 64'h0, 64'h0);

        // Out-of-range address: zero data and error with the check, aliasing without it.
        run("bounds_read", 2'b00, 64'h1 << (DL2 + 3), 64'h0, 64'h0);
        run("bounds_write", 2'b01, 64'h1 << (DL2 + 3), 64'h5555_5555_5555_5555, '1);
        run("bounds_word0", 2'b00, 64'h0, 64'h0, 64'h0);

        for (int i = 0; i < 150; i++) begin
            op  = 2'($urandom_range(0, 3));
            idx = (64'($urandom_range(0, DEPTH - 1)) << 3) | 64'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) idx = idx | ({$urandom, $urandom} << (DL2 + 3));
            case ($urandom_range(0, 3))
                0:       msk = '1;
                1:       msk = '0;
                default: msk = {$urandom, $urandom};
            endcase
            run($sformatf("rand%0d", i), op, idx, {$urandom, $urandom}, msk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
